alu_datapath_ctrl: RTL and testbench

- Moore FSM that sequences the 16-bit datapath for one instruction at a time.
- Datapath: register file, A/B operand registers, shifter, ALU, C result register and 3-bit status register (N,V,Z).
- Accepts an instruction on a start strobe, decodes it, and drives register-file select, load enables, mux selects, shift and ALUop over several cycles. Raises `w` when idle.
- Sits between the instruction source and the datapath; the ALU is driven purely by this block's `alu_op`.

---
 rtl/alu_ctrl_pkg.sv | 87 ++++++++
 rtl/alu_datapath_ctrl_decoder.sv | 56 +++++
 rtl/alu_datapath_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu_datapath_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU datapath controller.
// Contents: datapath widths, FSM state encoding, instruction opcode and ALU op encodings,
// instruction field bit positions, instruction classes, and the registered control-word
// bundle that drives the datapath.
package alu_ctrl_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned RnW   = 3;

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StGetA,
        StGetB,
        StExec,
        StWriteReg,
        StWriteImm
    } state_e;

    // Instruction opcodes (ireg[15:13])
    localparam logic [2:0] OpcMov = 3'b110;
    localparam logic [2:0] OpcAlu = 3'b101;

    // ALU operation encodings; the ALU-class op field uses the same encoding
    localparam logic [1:0] AluAdd  = 2'b00;
    localparam logic [1:0] AluSub  = 2'b01;
    localparam logic [1:0] AluAnd  = 2'b10;
    localparam logic [1:0] AluNotB = 2'b11;

    // op field values under the MOV opcode
    localparam logic [1:0] OpMovImm = 2'b10;
    localparam logic [1:0] OpMovReg = 2'b00;

    // Field LSB positions within the instruction word
    localparam int unsigned OpcLsb = 13;  // [15:13]
    localparam int unsigned OpLsb  = 11;  // [12:11]
    localparam int unsigned RnLsb  = 8;   // [10:8]
    localparam int unsigned RdLsb  = 5;   // [7:5]
    localparam int unsigned ShLsb  = 3;   // [4:3]
    localparam int unsigned RmLsb  = 0;   // [2:0]
    localparam int unsigned ImmLsb = 0;   // [7:0]

    typedef enum logic [2:0] {
        ClsMovImm,
        ClsMovReg,
        ClsAlu2,     // ADD, AND: two register operands, result written back
        ClsMvn,
        ClsCmp,
        ClsIllegal
    } instr_cls_e;

    // Everything the FSM drives toward the datapath, held in one register
    typedef struct packed {
        logic           w;
        logic [RnW-1:0] rnum;
        logic           write;
        logic           vsel;
        logic           loada;
        logic           loadb;
        logic           loadc;
        logic           loads;
        logic           asel;
        logic [1:0]     shift;
        logic [1:0]     alu_op;
        logic           illegal;
    } ctrl_t;

    localparam ctrl_t CtrlWait = '{
        w:       1'b1,
        rnum:    '0,
        write:   1'b0,
        vsel:    1'b0,
        loada:   1'b0,
        loadb:   1'b0,
        loadc:   1'b0,
        loads:   1'b0,
        asel:    1'b0,
        shift:   2'b00,
        alu_op:  AluAdd,
        illegal: 1'b0
    };

    function automatic logic [DataW-1:0] sext_imm8(input logic [7:0] imm8);
        return {{(DataW - 8){imm8[7]}}, imm8};
    endfunction

endpackage

// File: rtl/alu_datapath_ctrl_decoder.sv
// instr_decoder: purely combinational instruction field splitter and classifier.
// Ports:
//   instr   in   instruction word
//   op      out  op field [12:11]
//   rn      out  Rn field [10:8]
//   rd      out  Rd field [7:5]
//   rm      out  Rm field [2:0]
//   sh      out  shift field [4:3]
//   sximm8  out  sign-extended imm8
//   cls     out  instruction class
module instr_decoder
    import alu_ctrl_pkg::*;
(
    input  logic [DataW-1:0] instr,
    output logic [1:0]       op,
    output logic [RnW-1:0]   rn,
    output logic [RnW-1:0]   rd,
    output logic [RnW-1:0]   rm,
    output logic [1:0]       sh,
    output logic [DataW-1:0] sximm8,
    output instr_cls_e       cls
);

    logic [2:0] opcode;

    assign opcode = instr[OpcLsb +: 3];
    assign op     = instr[OpLsb +: 2];
    assign rn     = instr[RnLsb +: RnW];
    assign rd     = instr[RdLsb +: RnW];
    assign rm     = instr[RmLsb +: RnW];
    assign sh     = instr[ShLsb +: 2];
    assign sximm8 = sext_imm8(instr[ImmLsb +: 8]);

    always_comb begin
        cls = ClsIllegal;
        case (opcode)
            OpcMov: begin
                if (op == OpMovImm) begin
                    cls = ClsMovImm;
                end else if (op == OpMovReg) begin
                    cls = ClsMovReg;
                end
            end
            OpcAlu: begin
                unique case (op)
                    AluAdd, AluAnd: cls = ClsAlu2;
                    AluSub:         cls = ClsCmp;
                    AluNotB:        cls = ClsMvn;
                    default:        cls = ClsIllegal;
                endcase
            end
            default: cls = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/alu_datapath_ctrl.sv
// alu_datapath_ctrl: Moore FSM sequencing a 16-bit register-file/shifter/ALU datapath
// through one instruction at a time.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   s, in               start strobe and instruction, sampled only while idle (w=1)
//   w                   high only while idle
//   rnum, write, vsel   register-file number, write enable, writeback source (1=sximm8)
//   sximm8              sign-extended imm8 of the held instruction
//   loada..loads        operand A/B, result C and status load enables
//   asel, bsel          ALU A forced to 0 (MOV reg) / B source (fixed shifter)
//   shift, alu_op       shifter control and ALU operation
//   illegal             one-cycle pulse when an undefined instruction is decoded
// All control outputs are registered: the next-state control word is computed from the
// next state and next instruction register, so the outputs still depend only on state and
// ireg, never combinationally on s or in.
module alu_datapath_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned RN_W   = RnW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [DATA_W-1:0] in,
    output logic              w,
    output logic [RN_W-1:0]   rnum,
    output logic              write,
    output logic              vsel,
    output logic [DATA_W-1:0] sximm8,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        alu_op,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ireg_q, ireg_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] sximm8_q, sximm8_d;

    logic [1:0]        dec_op;
    logic [RN_W-1:0]   dec_rn, dec_rd, dec_rm;
    logic [1:0]        dec_sh;
    instr_cls_e        dec_cls;

    // Decodes ireg_d: outside WAIT it equals ireg_q, and on the capture edge it is the new
    // instruction, which is what the registered outputs of the next state need.
    instr_decoder u_decoder (
        .instr  (ireg_d),
        .op     (dec_op),
        .rn     (dec_rn),
        .rd     (dec_rd),
        .rm     (dec_rm),
        .sh     (dec_sh),
        .sximm8 (sximm8_d),
        .cls    (dec_cls)
    );

    always_comb begin
        state_d = state_q;
        ireg_d  = ireg_q;
        unique case (state_q)
            StWait: begin
                if (s) begin
                    ireg_d  = in;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                unique case (dec_cls)
                    ClsMovImm:         state_d = StWriteImm;
                    ClsMovReg, ClsMvn: state_d = StGetB;
                    ClsAlu2, ClsCmp:   state_d = StGetA;
                    default:           state_d = StWait;
                endcase
            end
            StGetA:     state_d = StGetB;
            StGetB:     state_d = StExec;
            StExec:     state_d = (dec_cls == ClsCmp) ? StWait : StWriteReg;
            StWriteReg: state_d = StWait;
            StWriteImm: state_d = StWait;
            default:    state_d = StWait;
        endcase
    end

    // Control word for the state being entered
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            StWait: ctrl_d = CtrlWait;
            StDecode: begin
                ctrl_d.illegal = (dec_cls == ClsIllegal);
            end
            StGetA: begin
                ctrl_d.rnum  = dec_rn;
                ctrl_d.loada = 1'b1;
            end
            StGetB: begin
                ctrl_d.rnum  = dec_rm;
                ctrl_d.loadb = 1'b1;
            end
            StExec: begin
                ctrl_d.shift  = dec_sh;
                ctrl_d.alu_op = (dec_cls == ClsMovReg) ? AluAdd : dec_op;
                // MOV reg computes 0 + shifted Rm
                ctrl_d.asel   = (dec_cls == ClsMovReg);
                ctrl_d.loads  = (dec_cls == ClsCmp);
                ctrl_d.loadc  = (dec_cls != ClsCmp);
            end
            StWriteReg: begin
                ctrl_d.rnum  = dec_rd;
                ctrl_d.write = 1'b1;
            end
            StWriteImm: begin
                ctrl_d.rnum  = dec_rn;
                ctrl_d.vsel  = 1'b1;
                ctrl_d.write = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StWait;
            ireg_q   <= '0;
            ctrl_q   <= CtrlWait;
            sximm8_q <= '0;
        end else begin
            state_q  <= state_d;
            ireg_q   <= ireg_d;
            ctrl_q   <= ctrl_d;
            sximm8_q <= sximm8_d;
        end
    end

    assign w       = ctrl_q.w;
    assign rnum    = ctrl_q.rnum;
    assign write   = ctrl_q.write;
    assign vsel    = ctrl_q.vsel;
    assign loada   = ctrl_q.loada;
    assign loadb   = ctrl_q.loadb;
    assign loadc   = ctrl_q.loadc;
    assign loads   = ctrl_q.loads;
    assign asel    = ctrl_q.asel;
    assign bsel    = 1'b0;
    assign shift   = ctrl_q.shift;
    assign alu_op  = ctrl_q.alu_op;
    assign illegal = ctrl_q.illegal;
    assign sximm8  = sximm8_q;

endmodule

// File: tb/tb_alu_datapath_ctrl.sv
// Scoreboard bench for alu_datapath_ctrl: the stimulus thread pushes a hand-written
// per-cycle expected output trace for each instruction; the monitor pops one entry per
// clock and compares it with the DUT outputs.
module tb_alu_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] instr;
    logic        w, write, vsel, loada, loadb, loadc, loads, asel, bsel, illegal;
    logic [2:0]  rnum;
    logic [15:0] sximm8;
    logic [1:0]  shift, alu_op;

    always #5 clk = ~clk;

    alu_datapath_ctrl #(
        .DATA_W (16),
        .RN_W   (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .in      (instr),
        .w       (w),
        .rnum    (rnum),
        .write   (write),
        .vsel    (vsel),
        .sximm8  (sximm8),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .shift   (shift),
        .alu_op  (alu_op),
        .illegal (illegal)
    );

    typedef struct packed {
        logic        w;
        logic [2:0]  rnum;
        logic        write;
        logic        vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  alu_op;
        logic        illegal;
        logic [15:0] sximm8;
    } obs_t;

    obs_t  exp_q[$];
    string nm_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // Args: w, rnum, write, vsel, loada, loadb, loadc, loads, asel, shift, alu_op, illegal, imm
    function automatic obs_t mk(input logic w_, input logic [2:0] rn, input logic wr,
                                input logic vs, input logic la, input logic lb, input logic lc,
                                input logic ls, input logic as, input logic [1:0] sh,
                                input logic [1:0] op, input logic il, input logic [15:0] im);
        return {w_, rn, wr, vs, la, lb, lc, ls, as, 1'b0, sh, op, il, im};
    endfunction

    function automatic obs_t idle(input logic [15:0] im);
        return mk(1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, im);
    endfunction

    function automatic obs_t dec(input logic [15:0] im);
        return mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, im);
    endfunction

    task automatic check(input string nm, input obs_t e);
        obs_t a;
        a = {w, rnum, write, vsel, loada, loadb, loadc, loads, asel, bsel, shift, alu_op,
             illegal, sximm8};
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic push(input string nm, input obs_t e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // Bounded wait for the monitor to consume every queued expectation
    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 64) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
            nm_q.delete();
        end
    endtask

    task automatic issue(input logic [15:0] ins);
        drain();
        @(negedge clk);
        s     = 1'b1;
        instr = ins;
    endtask

    task automatic release_s();
        @(negedge clk);
        s     = 1'b0;
        instr = 16'h1234;
    endtask

    // Monitor: one expected entry per clock while any are queued
    initial begin : monitor
        obs_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                check(n, e);
            end
        end
    end

    initial begin : stim
        reset = 1'b1;
        s     = 1'b0;
        instr = 16'h0000;
        #2;
        check("reset_state", idle(16'h0000));
        @(negedge clk);
        reset = 1'b0;

        // MOV R0,#-5
        issue(16'hD0FB);
        push("movi_decode", dec(16'hFFFB));
        push("movi_write",  mk(0, 3'd0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'hFFFB));
        push("movi_w",      idle(16'hFFFB));
        release_s();

        // ADD R2,R1,R0 LSL#1
        issue(16'hA148);
        push("add_decode", dec(16'h0048));
        push("add_geta",   mk(0, 3'd1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0048));
        push("add_getb",   mk(0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0048));
        push("add_exec",   mk(0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 16'h0048));
        push("add_write",  mk(0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0048));
        push("add_w",      idle(16'h0048));
        release_s();

        // CMP R3,R4
        issue(16'hAB04);
        push("cmp_decode", dec(16'h0004));
        push("cmp_geta",   mk(0, 3'd3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0004));
        push("cmp_getb",   mk(0, 3'd4, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0004));
        push("cmp_exec",   mk(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 0, 16'h0004));
        push("cmp_w",      idle(16'h0004));
        release_s();

        // MVN R5,R6
        issue(16'hB8A6);
        push("mvn_decode", dec(16'hFFA6));
        push("mvn_getb",   mk(0, 3'd6, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'hFFA6));
        push("mvn_exec",   mk(0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b11, 0, 16'hFFA6));
        push("mvn_write",  mk(0, 3'd5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'hFFA6));
        push("mvn_w",      idle(16'hFFA6));
        release_s();

        // MOV R7,R1
        issue(16'hC0E1);
        push("movr_decode", dec(16'hFFE1));
        push("movr_getb",   mk(0, 3'd1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'hFFE1));
        push("movr_exec",   mk(0, 3'd0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 16'hFFE1));
        push("movr_write",  mk(0, 3'd7, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'hFFE1));
        push("movr_w",      idle(16'hFFE1));
        release_s();

        // Undefined instruction
        issue(16'h0000);
        push("ill_decode", mk(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 16'h0000));
        push("ill_w",      idle(16'h0000));
        release_s();

        // s held high: MOV R1,#5 then MOV R2,#-128, in changes mid-instruction
        issue(16'hD105);
        push("b2b1_decode", dec(16'h0005));
        push("b2b1_write",  mk(0, 3'd1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0005));
        push("b2b_gap_w",   idle(16'h0005));
        push("b2b2_decode", dec(16'hFF80));
        push("b2b2_write",  mk(0, 3'd2, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'hFF80));
        push("b2b2_w",      idle(16'hFF80));
        @(negedge clk);
        instr = 16'h0000;      // DECODE cycle: must be ignored
        @(negedge clk);
        instr = 16'hD280;      // sampled in the single WAIT cycle that follows
        @(negedge clk);
        @(negedge clk);
        s     = 1'b0;
        instr = 16'hFFFF;

        // Asynchronous reset during GET_B of ADD R2,R1,R0 LSL#1
        issue(16'hA148);
        push("rst_add_decode", dec(16'h0048));
        push("rst_add_geta",   mk(0, 3'd1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0048));
        push("rst_add_getb",   mk(0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0048));
        release_s();
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", idle(16'h0000));
        push("rst_hold",   idle(16'h0000));
        push("rst_after1", idle(16'h0000));
        push("rst_after2", idle(16'h0000));
        @(negedge clk);
        reset = 1'b0;

        // Clean instruction after reset: MOV R3,#7
        issue(16'hD307);
        push("post_decode", dec(16'h0007));
        push("post_write",  mk(0, 3'd3, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0007));
        push("post_w",      idle(16'h0007));
        release_s();

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
